// File: rtl/xadc_multich_sampler.sv
// Multi-channel XADC sequencer: converts each enabled VAUX channel 2^k times over DRP,
// averages the samples and emits one tagged result per channel, with handshake timeouts.
module xadc_multich_sampler #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned NB_DATA      = 12,
  parameter int unsigned MAX_AVG_LOG2 = 3,
  parameter logic [6:0]  CH_ADDR_BASE = 7'h16,
  parameter int unsigned TIMEOUT      = 1024,
  localparam int unsigned AW  = (MAX_AVG_LOG2 > 0) ? $clog2(MAX_AVG_LOG2 + 1) : 1,
  localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [N_CH-1:0]    i_ch_mask,
  input  logic [AW-1:0]      i_avg_log2,
  output logic               o_convst,
  input  logic               i_eoc,
  output logic               o_den,
  output logic [6:0]         o_daddr,
  input  logic               i_drdy,
  input  logic [15:0]        i_do,
  output logic               o_busy,
  output logic               o_valid,
  output logic [CHW-1:0]     o_ch,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_done,
  output logic               o_timeout_err
);

  localparam int unsigned ACCW = NB_DATA + MAX_AVG_LOG2;
  localparam int unsigned CNTW = MAX_AVG_LOG2 + 1;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle, StSelect, StConv, StWaitEoc, StRead, StWaitDrdy, StAccum, StEmit, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [N_CH-1:0]    mask_q, mask_d;
  logic [AW-1:0]      avg_q, avg_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [NB_DATA-1:0] sample_q, sample_d;
  logic [ACCW-1:0]    acc_q, acc_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [6:0]         daddr_q, daddr_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [CHW-1:0]     och_q, och_d;
  logic               err_q, err_d;

  logic [CHW-1:0]     sel_ch;
  logic [AW-1:0]      avg_clamped;
  logic [31:0]        avg_req;
  logic [ACCW-1:0]    acc_sum;
  logic [CNTW-1:0]    cnt_inc;
  logic [CNTW-1:0]    cnt_target;

  // Lowest set bit of the remaining mask; scanning downward leaves the lowest index last.
  always_comb begin
    sel_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) sel_ch = CHW'(i);
    end
  end

  always_comb begin
    avg_req     = 32'(i_avg_log2);
    avg_clamped = i_avg_log2;
    if (avg_req > MAX_AVG_LOG2) avg_clamped = AW'(MAX_AVG_LOG2);
  end

  assign acc_sum    = acc_q + ACCW'(sample_q);
  assign cnt_inc    = cnt_q + CNTW'(1);
  assign cnt_target = CNTW'(1) << avg_q;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    avg_d    = avg_q;
    ch_d     = ch_q;
    tmo_d    = tmo_q;
    sample_d = sample_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    daddr_d  = daddr_q;
    data_d   = data_q;
    och_d    = och_q;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          mask_d  = i_ch_mask;
          avg_d   = avg_clamped;
          err_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StSelect;
        end
      end
      StSelect: begin
        if (mask_q == '0) begin
          state_d = StDone;
        end else begin
          ch_d    = sel_ch;
          mask_d  = mask_q & (mask_q - N_CH'(1));
          state_d = StConv;
        end
      end
      StConv: begin
        tmo_d   = '0;
        state_d = StWaitEoc;
      end
      StWaitEoc: begin
        if (i_eoc) begin
          daddr_d = CH_ADDR_BASE + 7'(ch_q);
          state_d = StRead;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StRead: begin
        tmo_d   = '0;
        state_d = StWaitDrdy;
      end
      StWaitDrdy: begin
        if (i_drdy) begin
          sample_d = i_do[15 -: NB_DATA];
          state_d  = StAccum;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StAccum: begin
        acc_d = acc_sum;
        cnt_d = cnt_inc;
        if (cnt_inc < cnt_target) begin
          state_d = StConv;
        end else begin
          // Result registers load here so they are already stable during the valid strobe.
          data_d  = NB_DATA'(acc_sum >> avg_q);
          och_d   = ch_q;
          state_d = StEmit;
        end
      end
      StEmit: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = StSelect;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mask_q   <= '0;
      avg_q    <= '0;
      ch_q     <= '0;
      tmo_q    <= '0;
      sample_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      daddr_q  <= '0;
      data_q   <= '0;
      och_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      avg_q    <= avg_d;
      ch_q     <= ch_d;
      tmo_q    <= tmo_d;
      sample_q <= sample_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      daddr_q  <= daddr_d;
      data_q   <= data_d;
      och_q    <= och_d;
      err_q    <= err_d;
    end
  end

  assign o_convst      = (state_q == StConv);
  assign o_den         = (state_q == StRead);
  assign o_valid       = (state_q == StEmit);
  assign o_done        = (state_q == StDone);
  assign o_busy        = (state_q != StIdle) && (state_q != StDone);
  assign o_daddr       = daddr_q;
  assign o_ch          = och_q;
  assign o_data        = data_q;
  assign o_timeout_err = err_q;

endmodule
